// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the shared carry-chain slice.
  localparam int NIB_W = 4;

  // Width of the nibble index; a single-nibble word still needs one bit.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_add4_cin.sv
// 4-bit combinational ripple adder slice with carry in and carry out.
module add4_cin
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  // One extra bit on the left catches the carry out of the slice.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Add/subtract sequencer that walks one shared 4-bit slice across a WIDTH-bit
// operand pair, least significant nibble first, carrying through a register.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t state, state_next;

  logic [NIB-1:0][NIB_W-1:0] opa, opb, result;
  logic                      carry;
  logic                      ovf_r;
  logic [IDX_W-1:0]          idx;
  logic [NIB_W-1:0]          slice_sum;
  logic                      slice_cout;
  logic                      accept;
  logic                      last;

  // Two's-complement overflow: like-signed operands giving an unlike-signed result.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  assign accept = in_ready & in_valid;
  assign last   = (idx == LAST_IDX);

  add4_cin u_slice (
    .a    (opa[idx]),
    .b    (opb[idx]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs, decoded from state only.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture; subtraction is folded into an inverted B plus carry-in of 1.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa <= a;
      opb <= sub ? ~b : b;
    end
  end

  // Result, carry, index and overflow: cleared on accept, stepped once per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      carry  <= 1'b0;
      ovf_r  <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      result <= '0;
      carry  <= sub ? 1'b1 : cin;
      ovf_r  <= 1'b0;
      idx    <= '0;
    end else if (state == RUN) begin
      result[idx] <= slice_sum;
      carry       <= slice_cout;
      if (last) begin
        ovf_r <= add_ovf(opa[NIB-1][NIB_W-1], opb[NIB-1][NIB_W-1], slice_sum[NIB_W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum  = result;
  assign cout = carry;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against an arithmetic model.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plain integer arithmetic: unsigned for sum/carry, signed range for overflow.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                       input logic ms, output logic [15:0] rs, output logic rc,
                       output logic ro);
    int full;
    int sr;
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = ma;
    sb = mb;
    if (ms) begin
      full = int'(ma) - int'(mb);
      rs   = full[15:0];
      rc   = (ma >= mb);
      sr   = int'(sa) - int'(sb);
    end else begin
      full = int'(ma) + int'(mb) + int'(mc);
      rs   = full[15:0];
      rc   = full[16];
      sr   = int'(sa) + int'(sb) + int'(mc);
    end
    ro = (sr > 32767) || (sr < -32768);
  endtask

  // One full transaction: accept, wait for result, optional backpressure, drain.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input logic ts, input int hold);
    logic [15:0] es;
    logic        ec;
    logic        eo;
    int          n;
    model(ta, tb, tc, ts, es, ec, eo);
    chk("in_ready_before", in_ready, 1);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    step();
    n = 0;
    while (!out_valid && n < 20) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      step();
      n++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("latency", n, 4);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("ovf", ovf, eo);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_sum", sum, es);
      chk("hold_cout", cout, ec);
      chk("hold_ovf", ovf, eo);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 5);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1);
    run_op(16'h0003, 16'h0005, 1'b0, 1'b1, 0);
    run_op(16'h0000, 16'h8000, 1'b0, 1'b1, 0);
    run_op(16'hABCD, 16'hABCD, 1'b1, 1'b1, 0);

    // Abandon an operation two nibbles in.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
